// File: rtl/mem_arb.sv
// rtl/mem_arb.sv - two-port round-robin memory arbiter with request/response sequencing and timeout
module mem_arb #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                s0_valid,
  output logic                s0_ready,
  input  logic [ADDR_W-1:0]   s0_addr,
  input  logic                s0_wen,
  input  logic [DATA_W-1:0]   s0_wdata,
  input  logic [DATA_W/8-1:0] s0_wmask,
  output logic                s0_resp_valid,
  output logic [DATA_W-1:0]   s0_resp_rdata,
  output logic                s0_resp_err,
  input  logic                s1_valid,
  output logic                s1_ready,
  input  logic [ADDR_W-1:0]   s1_addr,
  input  logic                s1_wen,
  input  logic [DATA_W-1:0]   s1_wdata,
  input  logic [DATA_W/8-1:0] s1_wmask,
  output logic                s1_resp_valid,
  output logic [DATA_W-1:0]   s1_resp_rdata,
  output logic                s1_resp_err,
  output logic                mem_valid,
  input  logic                mem_ready,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic                mem_wen,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_wmask,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata
);

  localparam int MASK_W = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT);
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

  state_t              state_q;
  logic                owner_q;
  logic                last_grant_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                wen_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [MASK_W-1:0]   wmask_q;
  logic [CNT_W-1:0]    cnt_q;
  logic                mem_valid_q;
  logic                s0_resp_valid_q, s1_resp_valid_q;
  logic                s0_resp_err_q, s1_resp_err_q;
  logic [DATA_W-1:0]   s0_resp_rdata_q, s1_resp_rdata_q;

  logic grant0, grant1;
  logic timeout_hit;
  logic done, done_err;

  // On a tie the port that was not granted last wins.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state_q == IDLE) begin
      if (s0_valid && s1_valid) begin
        grant0 = last_grant_q;
        grant1 = !last_grant_q;
      end else begin
        grant0 = s0_valid;
        grant1 = s1_valid;
      end
    end
  end

  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LIMIT);

  // A real memory response in the same cycle as the timeout takes priority.
  always_comb begin
    done     = 1'b0;
    done_err = 1'b0;
    case (state_q)
      REQ: begin
        if (timeout_hit) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
      end
      RESP: begin
        if (mem_rvalid) begin
          done = 1'b1;
        end else if (timeout_hit) begin
          done     = 1'b1;
          done_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q         <= IDLE;
      owner_q         <= 1'b0;
      last_grant_q    <= 1'b1;
      addr_q          <= '0;
      wen_q           <= 1'b0;
      wdata_q         <= '0;
      wmask_q         <= '0;
      cnt_q           <= '0;
      mem_valid_q     <= 1'b0;
      s0_resp_valid_q <= 1'b0;
      s1_resp_valid_q <= 1'b0;
      s0_resp_err_q   <= 1'b0;
      s1_resp_err_q   <= 1'b0;
      s0_resp_rdata_q <= '0;
      s1_resp_rdata_q <= '0;
    end else begin
      s0_resp_valid_q <= done && !owner_q;
      s1_resp_valid_q <= done && owner_q;
      s0_resp_err_q   <= done && done_err && !owner_q;
      s1_resp_err_q   <= done && done_err && owner_q;
      s0_resp_rdata_q <= (done && !done_err && !wen_q && !owner_q) ? mem_rdata : '0;
      s1_resp_rdata_q <= (done && !done_err && !wen_q && owner_q) ? mem_rdata : '0;
      case (state_q)
        IDLE: begin
          if (grant0 || grant1) begin
            addr_q       <= grant1 ? s1_addr : s0_addr;
            wen_q        <= grant1 ? s1_wen : s0_wen;
            wdata_q      <= grant1 ? s1_wdata : s0_wdata;
            wmask_q      <= grant1 ? s1_wmask : s0_wmask;
            owner_q      <= grant1;
            last_grant_q <= grant1;
            cnt_q        <= '0;
            mem_valid_q  <= 1'b1;
            state_q      <= REQ;
          end
        end
        REQ: begin
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          if (done) begin
            mem_valid_q <= 1'b0;
            state_q     <= IDLE;
          end else if (mem_ready) begin
            mem_valid_q <= 1'b0;
            state_q     <= RESP;
          end
        end
        RESP: begin
          if (cnt_q != '1) cnt_q <= cnt_q + 1'b1;
          if (done) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign s0_ready      = grant0;
  assign s1_ready      = grant1;
  assign s0_resp_valid = s0_resp_valid_q;
  assign s1_resp_valid = s1_resp_valid_q;
  assign s0_resp_err   = s0_resp_err_q;
  assign s1_resp_err   = s1_resp_err_q;
  assign s0_resp_rdata = s0_resp_rdata_q;
  assign s1_resp_rdata = s1_resp_rdata_q;
  assign mem_valid     = mem_valid_q;
  assign mem_addr      = mem_valid_q ? addr_q : '0;
  assign mem_wen       = mem_valid_q && wen_q;
  assign mem_wdata     = mem_valid_q ? wdata_q : '0;
  assign mem_wmask     = mem_valid_q ? wmask_q : '0;

endmodule

// File: tb/tb_mem_arb.sv
// tb/tb_mem_arb.sv - scoreboard bench for mem_arb; second instance with TIMEOUT=8 covers the timeout path
module tb_mem_arb;
  localparam logic [31:0] KEY = 32'h80100073;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        s0_valid = 0, s0_wen = 0, s1_valid = 0, s1_wen = 0;
  logic [31:0] s0_addr = 0, s0_wdata = 0, s1_addr = 0, s1_wdata = 0;
  logic [3:0]  s0_wmask = 0, s1_wmask = 0;
  logic        mem_ready = 1, mem_rvalid = 1;
  logic [31:0] mem_rdata;
  logic [31:0] mem_last_addr = 32'h0;

  logic        s0_ready, s1_ready, s0_resp_valid, s1_resp_valid, s0_resp_err, s1_resp_err;
  logic [31:0] s0_resp_rdata, s1_resp_rdata;
  logic        mem_valid, mem_wen;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_wmask;

  logic        b_s0_ready, b_s1_ready, b_s0_resp_valid, b_s1_resp_valid, b_s0_resp_err, b_s1_resp_err;
  logic [31:0] b_s0_resp_rdata, b_s1_resp_rdata;
  logic        b_mem_valid, b_mem_wen;
  logic [31:0] b_mem_addr, b_mem_wdata;
  logic [3:0]  b_mem_wmask;

  int checks = 0;
  int errors = 0;
  logic [32:0] q0[$];
  logic [32:0] q1[$];

  // Memory model: read data is the accepted address xor'ed with a key.
  always @(posedge clk) if (mem_valid && mem_ready) mem_last_addr <= mem_addr;
  assign mem_rdata = mem_last_addr ^ KEY;

  mem_arb dut (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(s0_ready), .s0_addr(s0_addr), .s0_wen(s0_wen),
    .s0_wdata(s0_wdata), .s0_wmask(s0_wmask), .s0_resp_valid(s0_resp_valid),
    .s0_resp_rdata(s0_resp_rdata), .s0_resp_err(s0_resp_err),
    .s1_valid(s1_valid), .s1_ready(s1_ready), .s1_addr(s1_addr), .s1_wen(s1_wen),
    .s1_wdata(s1_wdata), .s1_wmask(s1_wmask), .s1_resp_valid(s1_resp_valid),
    .s1_resp_rdata(s1_resp_rdata), .s1_resp_err(s1_resp_err),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr), .mem_wen(mem_wen),
    .mem_wdata(mem_wdata), .mem_wmask(mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  mem_arb #(.TIMEOUT(8)) dut_to (
    .clk(clk), .rst(rst),
    .s0_valid(s0_valid), .s0_ready(b_s0_ready), .s0_addr(s0_addr), .s0_wen(s0_wen),
    .s0_wdata(s0_wdata), .s0_wmask(s0_wmask), .s0_resp_valid(b_s0_resp_valid),
    .s0_resp_rdata(b_s0_resp_rdata), .s0_resp_err(b_s0_resp_err),
    .s1_valid(s1_valid), .s1_ready(b_s1_ready), .s1_addr(s1_addr), .s1_wen(s1_wen),
    .s1_wdata(s1_wdata), .s1_wmask(s1_wmask), .s1_resp_valid(b_s1_resp_valid),
    .s1_resp_rdata(b_s1_resp_rdata), .s1_resp_err(b_s1_resp_err),
    .mem_valid(b_mem_valid), .mem_ready(mem_ready), .mem_addr(b_mem_addr), .mem_wen(b_mem_wen),
    .mem_wdata(b_mem_wdata), .mem_wmask(b_mem_wmask), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always @(negedge clk) begin
    if (s0_resp_valid) begin
      checks++;
      if (q0.size() == 0) begin
        errors++;
        $display("FAIL s0_resp_unexpected got err=%b rdata=%h exp no pulse", s0_resp_err, s0_resp_rdata);
      end else begin
        logic [32:0] e0;
        e0 = q0.pop_front();
        if ({s0_resp_err, s0_resp_rdata} !== e0) begin
          errors++;
          $display("FAIL s0_resp got %h exp %h", {s0_resp_err, s0_resp_rdata}, e0);
        end
      end
    end
    if (s1_resp_valid) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL s1_resp_unexpected got err=%b rdata=%h exp no pulse", s1_resp_err, s1_resp_rdata);
      end else begin
        logic [32:0] e1;
        e1 = q1.pop_front();
        if ({s1_resp_err, s1_resp_rdata} !== e1) begin
          errors++;
          $display("FAIL s1_resp got %h exp %h", {s1_resp_err, s1_resp_rdata}, e1);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic wait_drain();
    int w = 0;
    while ((q0.size() != 0 || q1.size() != 0) && w < 40) begin
      sample();
      w++;
    end
    checks++;
    if (w >= 40) begin
      errors++;
      $display("FAIL drain got q0=%0d q1=%0d pending exp 0", q0.size(), q1.size());
      q0.delete();
      q1.delete();
    end
    step();
  endtask

  task automatic test_reset();
    rst = 1'b0;
    step();
    step();
    sample();
    checks++;
    if ({s0_ready, s1_ready, s0_resp_valid, s1_resp_valid, s0_resp_err, s1_resp_err,
         s0_resp_rdata, s1_resp_rdata, mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs got mem_valid=%b mem_addr=%h resp=%b%b exp all 0",
               mem_valid, mem_addr, s0_resp_valid, s1_resp_valid);
    end
    checks++;
    if ({b_s0_ready, b_s1_ready, b_s0_resp_valid, b_s1_resp_valid, b_s0_resp_err, b_s1_resp_err,
         b_s0_resp_rdata, b_s1_resp_rdata, b_mem_valid, b_mem_addr, b_mem_wen, b_mem_wdata,
         b_mem_wmask} !== '0) begin
      errors++;
      $display("FAIL reset_outputs_to got mem_valid=%b exp all 0", b_mem_valid);
    end
    step();
    rst = 1'b1;
  endtask

  task automatic test_round_robin();
    logic [31:0] exp_addr;
    step();
    s0_valid = 1; s0_addr = 32'h0000_1000; s0_wen = 0;
    s1_valid = 1; s1_addr = 32'h0000_2000; s1_wen = 0;
    for (int k = 0; k < 4; k++) begin
      int w = 0;
      sample();
      while (!(s0_ready || s1_ready) && w < 10) begin
        step();
        sample();
        w++;
      end
      checks++;
      if ({s1_ready, s0_ready} !== ((k % 2 == 1) ? 2'b10 : 2'b01)) begin
        errors++;
        $display("FAIL rr_grant%0d got %b exp %b", k, {s1_ready, s0_ready},
                 (k % 2 == 1) ? 2'b10 : 2'b01);
      end
      exp_addr = (k % 2 == 1) ? 32'h0000_2000 : 32'h0000_1000;
      if (k % 2 == 1) q1.push_back({1'b0, exp_addr ^ KEY});
      else q0.push_back({1'b0, exp_addr ^ KEY});
      step();
      if (k == 3) begin
        s0_valid = 0;
        s1_valid = 0;
      end
      sample();
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== exp_addr) begin
        errors++;
        $display("FAIL rr_addr%0d got valid=%b addr=%h exp 1 %h", k, mem_valid, mem_addr, exp_addr);
      end
    end
    wait_drain();
  endtask

  task automatic test_single_read();
    step();
    s0_valid = 1; s0_addr = 32'h8000_0000; s0_wen = 0;
    sample();
    checks++;
    if ({s0_ready, s1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rd_ready got %b exp 10", {s0_ready, s1_ready});
    end
    q0.push_back({1'b0, 32'h0010_0073});
    step();
    s0_valid = 0; s0_addr = 32'hFFFF_FFFF;
    sample();
    checks++;
    if (mem_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0) begin
      errors++;
      $display("FAIL rd_req got valid=%b addr=%h wen=%b exp 1 80000000 0", mem_valid, mem_addr, mem_wen);
    end
    step();
    sample();
    checks++;
    if (mem_valid !== 1'b0 || mem_addr !== 32'h0) begin
      errors++;
      $display("FAIL rd_resp_phase got valid=%b addr=%h exp 0 0", mem_valid, mem_addr);
    end
    step();
    sample();
    checks++;
    if (s0_resp_valid !== 1'b1 || s1_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_latency got s0=%b s1=%b exp 1 0", s0_resp_valid, s1_resp_valid);
    end
    step();
    sample();
    checks++;
    if (s0_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_pulse_width got %b exp 0", s0_resp_valid);
    end
    wait_drain();
  endtask

  task automatic test_write();
    step();
    s1_valid = 1; s1_addr = 32'h8000_1000; s1_wen = 1; s1_wdata = 32'hDEAD_BEEF; s1_wmask = 4'hF;
    sample();
    checks++;
    if ({s0_ready, s1_ready} !== 2'b01) begin
      errors++;
      $display("FAIL wr_ready got %b exp 01", {s0_ready, s1_ready});
    end
    q1.push_back(33'h0);
    step();
    s1_valid = 0; s1_addr = 0; s1_wen = 0; s1_wdata = 0; s1_wmask = 0;
    sample();
    checks++;
    if ({mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask} !==
        {1'b1, 1'b1, 32'h8000_1000, 32'hDEAD_BEEF, 4'hF}) begin
      errors++;
      $display("FAIL wr_req got v=%b wen=%b a=%h d=%h m=%h exp 1 1 80001000 deadbeef f",
               mem_valid, mem_wen, mem_addr, mem_wdata, mem_wmask);
    end
    wait_drain();
  endtask

  task automatic test_stall();
    mem_ready = 0;
    mem_rvalid = 0;
    step();
    s0_valid = 1; s0_addr = 32'h8000_0040; s0_wen = 0;
    sample();
    checks++;
    if (s0_ready !== 1'b1) begin
      errors++;
      $display("FAIL st_ready got %b exp 1", s0_ready);
    end
    q0.push_back({1'b0, 32'h8000_0040 ^ KEY});
    step();
    s0_valid = 0; s1_valid = 1; s1_addr = 32'h1234_5678;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) mem_ready = 1;
      sample();
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h8000_0040 || s1_ready !== 1'b0) begin
        errors++;
        $display("FAIL st_hold%0d got valid=%b addr=%h s1_ready=%b exp 1 80000040 0",
                 i, mem_valid, mem_addr, s1_ready);
      end
      step();
    end
    mem_ready = 0;
    for (int i = 0; i < 5; i++) begin
      sample();
      checks++;
      if (mem_valid !== 1'b0 || s0_resp_valid !== 1'b0 || s1_ready !== 1'b0) begin
        errors++;
        $display("FAIL st_wait%0d got valid=%b resp=%b s1_ready=%b exp 0 0 0",
                 i, mem_valid, s0_resp_valid, s1_ready);
      end
      step();
    end
    mem_rvalid = 1; mem_ready = 1; s1_valid = 0;
    sample();
    step();
    sample();
    checks++;
    if (s0_resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL st_resp got %b exp 1", s0_resp_valid);
    end
    wait_drain();
  endtask

  task automatic test_timeout();
    logic seen;
    step();
    rst = 0; mem_ready = 0; mem_rvalid = 0;
    step();
    rst = 1;
    step();
    s0_valid = 1; s0_addr = 32'h8000_0100; s0_wen = 0;
    sample();
    checks++;
    if (b_s0_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_ready got %b exp 1", b_s0_ready);
    end
    step();
    s0_valid = 0;
    seen = 1'b0;
    sample();
    if (b_s0_resp_valid !== 1'b0) seen = 1'b1;
    for (int i = 2; i < 10; i++) begin
      step();
      sample();
      if (b_s0_resp_valid !== 1'b0) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin
      errors++;
      $display("FAIL to_early got pulse before REQ+9 exp none");
    end
    step();
    s1_valid = 1; s1_addr = 32'h8000_0200;
    sample();
    checks++;
    if ({b_s0_resp_valid, b_s0_resp_err, b_s0_resp_rdata, b_mem_valid, b_s1_resp_valid} !==
        {1'b1, 1'b1, 32'h0, 1'b0, 1'b0}) begin
      errors++;
      $display("FAIL to_err got v=%b e=%b d=%h mv=%b s1=%b exp 1 1 0 0 0", b_s0_resp_valid,
               b_s0_resp_err, b_s0_resp_rdata, b_mem_valid, b_s1_resp_valid);
    end
    checks++;
    if (b_s1_ready !== 1'b1) begin
      errors++;
      $display("FAIL to_idle_ready got %b exp 1", b_s1_ready);
    end
    step();
    s1_valid = 0;
    sample();
    checks++;
    if (b_mem_valid !== 1'b1 || b_mem_addr !== 32'h8000_0200 || b_s0_resp_valid !== 1'b0) begin
      errors++;
      $display("FAIL to_next got v=%b a=%h r=%b exp 1 80000200 0", b_mem_valid, b_mem_addr, b_s0_resp_valid);
    end
    step();
    rst = 0; mem_ready = 1; mem_rvalid = 1;
    step();
    rst = 1;
  endtask

  task automatic test_reset_mid_resp();
    mem_ready = 1; mem_rvalid = 0;
    step();
    s0_valid = 1; s0_addr = 32'h8000_0300;
    sample();
    checks++;
    if (s0_ready !== 1'b1) begin
      errors++;
      $display("FAIL rm_ready got %b exp 1", s0_ready);
    end
    step();
    s0_valid = 0;
    sample();
    step();
    rst = 0; mem_rvalid = 1;
    sample();
    step();
    rst = 1;
    sample();
    checks++;
    if ({s0_resp_valid, s1_resp_valid, s0_resp_err, s1_resp_err, s0_resp_rdata, s1_resp_rdata,
         mem_valid, mem_addr, mem_wen, mem_wdata, mem_wmask, s0_ready, s1_ready} !== '0) begin
      errors++;
      $display("FAIL rm_outputs got resp=%b%b mem_valid=%b exp all 0", s0_resp_valid, s1_resp_valid, mem_valid);
    end
    step();
    s0_valid = 1; s0_addr = 32'h8000_0400; s1_valid = 1; s1_addr = 32'h8000_0500;
    sample();
    checks++;
    if ({s0_ready, s1_ready} !== 2'b10) begin
      errors++;
      $display("FAIL rm_tie got %b exp 10", {s0_ready, s1_ready});
    end
    q0.push_back({1'b0, 32'h8000_0400 ^ KEY});
    step();
    s0_valid = 0; s1_valid = 0;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_round_robin();
    test_single_read();
    test_write();
    test_stall();
    test_timeout();
    test_reset_mid_resp();
    repeat (3) step();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no completion exp finish");
    $fatal(1);
  end
endmodule
